// File: rtl/pixel_norm_pkg.sv
// Shared constants and helpers for the pixel normalisation pipeline.
package pixel_norm_pkg;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;

    // Half-LSB addend of the output format when rounding, zero when truncating
    // or when the output keeps every fractional bit.
    function automatic logic [63:0] round_addend(input int frac_w, input int out_w,
                                                 input int round_mode);
        if (round_mode == ROUND_HALF_UP && frac_w > out_w) begin
            return 64'd1 << (frac_w - out_w - 1);
        end
        return '0;
    endfunction

endpackage

// File: rtl/pixel_norm_lane.sv
// One channel: round the product, then saturate or take the output fraction bits.
module pixel_norm_lane
    import pixel_norm_pkg::*;
#(
    parameter int INT_WIDTH  = 8,
    parameter int FRAC_WIDTH = 12,
    parameter int OUT_WIDTH  = 8,
    parameter int ROUND      = ROUND_HALF_UP
) (
    input  logic [INT_WIDTH+FRAC_WIDTH-1:0] i_product,
    output logic [OUT_WIDTH-1:0]            o_pixel,
    output logic                            o_sat
);

    localparam int P_WIDTH = INT_WIDTH + FRAC_WIDTH;
    localparam logic [P_WIDTH-1:0] ADDEND =
        P_WIDTH'(round_addend(FRAC_WIDTH, OUT_WIDTH, ROUND));

    logic [P_WIDTH-1:0] w_rounded;
    logic               w_unused_bits;

    // Largest product plus the half-LSB addend still fits in P_WIDTH bits.
    assign w_rounded     = i_product + ADDEND;
    assign o_sat         = |w_rounded[P_WIDTH-1:FRAC_WIDTH];
    assign o_pixel       = o_sat ? '1 : w_rounded[FRAC_WIDTH-1 -: OUT_WIDTH];
    // Fraction bits below the output LSB are intentionally discarded.
    assign w_unused_bits = ^w_rounded;

endmodule

// File: rtl/pixel_norm_pipe.sv
// Two-stage pixel normaliser: S1 multiplies by the frame's norm factor,
// S2 registers the rounded/saturated result; elastic valid/ready handshake.
module pixel_norm_pipe
    import pixel_norm_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int INT_WIDTH  = 8,
    parameter int FRAC_WIDTH = 12,
    parameter int OUT_WIDTH  = 8,
    parameter int ROUND      = ROUND_HALF_UP,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_CH*INT_WIDTH-1:0] in_pixel,
    input  logic                      in_sof,
    input  logic                      in_eol,
    input  logic                      norm_load,
    input  logic [FRAC_WIDTH-1:0]     norm_factor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_CH*OUT_WIDTH-1:0] out_pixel,
    output logic                      out_sof,
    output logic                      out_eol,
    output logic [CNT_WIDTH-1:0]      sat_count,
    input  logic                      sat_clr
);

    localparam int P_WIDTH = INT_WIDTH + FRAC_WIDTH;

    if (FRAC_WIDTH < OUT_WIDTH) begin : g_bad_widths
        $error("pixel_norm_pipe: FRAC_WIDTH must be >= OUT_WIDTH");
    end

    logic                                w_s2_adv;
    logic                                w_s1_adv;
    logic                                w_accept;
    logic                                w_frame_start;
    logic [FRAC_WIDTH-1:0]               w_norm_used;
    logic [N_CH-1:0][P_WIDTH-1:0]        w_product;
    logic [N_CH-1:0][OUT_WIDTH-1:0]      w_lane_pixel;
    logic [N_CH-1:0]                     w_lane_sat;

    logic [FRAC_WIDTH-1:0]               r_shadow;
    logic [FRAC_WIDTH-1:0]               r_active;
    logic                                r_s1_valid;
    logic                                r_s1_sof;
    logic                                r_s1_eol;
    logic [N_CH-1:0][P_WIDTH-1:0]        r_s1_product;
    logic                                r_s2_valid;
    logic                                r_s2_sof;
    logic                                r_s2_eol;
    logic                                r_s2_sat;
    logic [N_CH-1:0][OUT_WIDTH-1:0]      r_s2_pixel;
    logic [CNT_WIDTH-1:0]                r_sat_count;

    // A stage moves when it is empty or its consumer takes its beat.
    assign w_s2_adv      = !r_s2_valid || out_ready;
    assign w_s1_adv      = !r_s1_valid || w_s2_adv;
    assign in_ready      = w_s1_adv;
    assign w_accept      = in_valid && in_ready;
    assign w_frame_start = w_accept && in_sof;

    // A frame-start beat picks up the newest factor (a same-cycle load bypasses
    // the shadow); every other beat keeps the factor latched for the frame.
    assign w_norm_used = !w_frame_start ? r_active
                       : (norm_load ? norm_factor : r_shadow);

    // Per-channel full-width unsigned products for the beat being accepted.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_product = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            w_product[ch] = {{FRAC_WIDTH{1'b0}}, in_pixel[ch*INT_WIDTH +: INT_WIDTH]}
                          * {{INT_WIDTH{1'b0}}, w_norm_used};
        end
    end

    // Shadow register takes every load; active factor changes only at frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            if (norm_load) begin
                r_shadow <= norm_factor;
            end
            if (w_frame_start) begin
                r_active <= w_norm_used;
            end
        end
    end

    // Stage 1: capture products and framing flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data registers are reset too, so outputs read as zero during reset.
            r_s1_valid   <= 1'b0;
            r_s1_sof     <= 1'b0;
            r_s1_eol     <= 1'b0;
            r_s1_product <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sof     <= in_sof;
                r_s1_eol     <= in_eol;
                r_s1_product <= w_product;
            end
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_lane
        pixel_norm_lane #(
            .INT_WIDTH  (INT_WIDTH),
            .FRAC_WIDTH (FRAC_WIDTH),
            .OUT_WIDTH  (OUT_WIDTH),
            .ROUND      (ROUND)
        ) u_lane (
            .i_product (r_s1_product[ch]),
            .o_pixel   (w_lane_pixel[ch]),
            .o_sat     (w_lane_sat[ch])
        );
    end

    // Stage 2: capture rounded/saturated pixels; hold them while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sof   <= 1'b0;
            r_s2_eol   <= 1'b0;
            r_s2_sat   <= 1'b0;
            r_s2_pixel <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sof   <= r_s1_sof;
                r_s2_eol   <= r_s1_eol;
                r_s2_sat   <= |w_lane_sat;
                r_s2_pixel <= w_lane_pixel;
            end
        end
    end

    // Count delivered beats with any saturated channel; clear wins, never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_count <= '0;
        end else if (sat_clr) begin
            r_sat_count <= '0;
        end else if (r_s2_valid && out_ready && r_s2_sat && (r_sat_count != '1)) begin
            r_sat_count <= r_sat_count + 1'b1;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_sof   = r_s2_sof;
    assign out_eol   = r_s2_eol;
    assign out_pixel = r_s2_pixel;
    assign sat_count = r_sat_count;

endmodule
